// File: rtl/reg_apb_mst_pkg.sv
// ============================================================================
// reg_apb_mst_pkg : shared state encoding and timeout read-data constant
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_apb_mst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hdead_1eaf;

endpackage

`default_nettype wire

// File: rtl/reg_apb_mst_tmr.sv
// ============================================================================
// reg_apb_mst_tmr : ACCESS-phase watchdog, flags the (TIMECNT+1)th wait cycle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_apb_mst_tmr #(
    parameter int TIMECNT = 99
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW     = (TIMECNT > 0) ? $clog2(TIMECNT + 1) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(TIMECNT);

    logic [CW-1:0] r_cnt;

    // Saturates at c_LAST so a stalled slave cannot wrap the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt != c_LAST) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/reg_apb_mst.sv
// ============================================================================
// reg_apb_mst : request/ack to APB master bridge (one transfer in flight)
// Optional ACCESS timeout enabled by defining REG_APB_MST_TIMEOUT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_apb_mst
    import reg_apb_mst_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int TIMECNT    = 99
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wr_en,
    input  logic                  req_rd_en,
    input  logic [DATA_WIDTH-1:0] req_wr_data,
    input  logic                  sync_reset,
    output logic                  ack_vld,
    input  logic                  ack_rdy,
    output logic [DATA_WIDTH-1:0] ack_rd_data,
    output logic                  ack_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    state_t r_state;
    logic   w_timeout;

    assign req_rdy = (r_state == IDLE);

`ifdef REG_APB_MST_TIMEOUT_EN
    reg_apb_mst_tmr #(
        .TIMECNT (TIMECNT)
    ) u_tmr (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (sync_reset),
        .i_en      (r_state == ACCESS),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWDATA      <= '0;
            ack_vld     <= 1'b0;
            ack_rd_data <= '0;
            ack_err     <= 1'b0;
        end else if (sync_reset) begin
            r_state     <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            ack_vld     <= 1'b0;
            ack_rd_data <= '0;
            ack_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_vld) begin
                        if (req_wr_en ^ req_rd_en) begin
                            PADDR   <= req_addr;
                            PWDATA  <= req_wr_data;
                            PWRITE  <= req_wr_en;
                            PSEL    <= 1'b1;
                            r_state <= SETUP;
                        end else begin
                            // Ambiguous command: answer with an error, never touch the bus.
                            ack_vld     <= 1'b1;
                            ack_err     <= 1'b1;
                            ack_rd_data <= '0;
                            r_state     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        ack_vld     <= 1'b1;
                        ack_err     <= PSLVERR;
                        ack_rd_data <= PWRITE ? '0 : PRDATA;
                        r_state     <= RESP;
                    end else if (w_timeout) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        ack_vld     <= 1'b1;
                        ack_err     <= 1'b1;
                        ack_rd_data <= DATA_WIDTH'(TIMEOUT_RDATA);
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (ack_rdy) begin
                        ack_vld <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_apb_mst.sv
// ============================================================================
// tb_reg_apb_mst : scoreboard bench with memory-backed APB slave model
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reg_apb_mst;

    localparam int AW        = 64;
    localparam int DW        = 32;
    localparam int c_TIMECNT = 99;
    localparam int c_NEVER   = 100000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_vld, req_rdy, req_wr_en, req_rd_en;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wr_data;
    logic          sync_reset;
    logic          ack_vld, ack_rdy, ack_err;
    logic [DW-1:0] ack_rd_data;
    logic [AW-1:0] PADDR;
    logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [DW-1:0] PWDATA, PRDATA;

    always #5 clk = ~clk;

    reg_apb_mst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMECNT(c_TIMECNT)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_addr(req_addr), .req_wr_en(req_wr_en), .req_rd_en(req_rd_en),
        .req_wr_data(req_wr_data), .sync_reset(sync_reset), .ack_vld(ack_vld),
        .ack_rdy(ack_rdy), .ack_rd_data(ack_rd_data), .ack_err(ack_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct { logic [31:0] data; logic err; int hold; } ack_t;
    typedef struct { logic [63:0] addr; logic wr; logic [31:0] wdata; int wt; logic err; } apb_t;

    ack_t        ack_q[$];
    apb_t        apb_q[$];
    logic [31:0] model_mem [logic [63:0]];
    logic [31:0] slave_mem [logic [63:0]];
    int n_tests = 0, n_fail = 0;
    int apb_seen = 0, apb_exp = 0, last_pen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] model_rd(input logic [63:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [63:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
    endfunction

    // APB slave: memory with per-transfer wait states and error taken from apb_q
    initial begin : slave
        apb_t c;
        bit   in_xfer = 0;
        int   acc_cnt = 0, pen = 0;
        PREADY = 0; PSLVERR = 0; PRDATA = '0;
        c = '{64'h0, 1'b0, 32'h0, 0, 1'b0};
        forever begin
            @(negedge clk);
            PREADY = 0; PSLVERR = 0;
            if (rst || !(PSEL && PENABLE)) begin
                in_xfer = 0; acc_cnt = 0;
            end else begin
                if (!in_xfer) begin
                    in_xfer = 1; acc_cnt = 0; pen = 0; apb_seen++;
                    if (apb_q.size() == 0) begin
                        check("apb_unexpected_xfer", 1, 0);
                        c = '{PADDR, PWRITE, PWDATA, c_NEVER, 1'b0};
                    end else begin
                        c = apb_q.pop_front();
                    end
                    check("PADDR", PADDR, c.addr);
                    check("PWRITE", PWRITE, c.wr);
                    if (c.wr) check("PWDATA", PWDATA, c.wdata);
                end else begin
                    check("PADDR_stable", PADDR, c.addr);
                    check("PWRITE_stable", PWRITE, c.wr);
                end
                pen++;
                last_pen = pen;
                if (acc_cnt == c.wt) begin
                    PREADY  = 1;
                    PSLVERR = c.err;
                    PRDATA  = PWRITE ? $urandom : slave_rd(PADDR);
                    if (PWRITE && !c.err) slave_mem[PADDR] = PWDATA;
                end
                acc_cnt++;
            end
        end
    end

    // Response monitor: pops the scoreboard on each new ack and applies its backpressure
    initial begin : monitor
        ack_t cur;
        bit   in_ack = 0;
        int   hold = 0;
        ack_rdy = 0;
        cur = '{32'h0, 1'b0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                in_ack = 0; ack_rdy = 0;
                continue;
            end
            if (ack_vld) begin
                if (!in_ack) begin
                    if (ack_q.size() == 0) begin
                        check("ack_unexpected", 1, 0);
                        cur = '{ack_rd_data, ack_err, 0};
                    end else begin
                        cur = ack_q.pop_front();
                    end
                    in_ack = 1;
                    hold = cur.hold;
                end
                check("ack_rd_data", ack_rd_data, cur.data);
                check("ack_err", ack_err, cur.err);
                ack_rdy = (hold == 0);
                if (hold > 0) hold--;
                if (ack_rdy) in_ack = 0;
            end else begin
                if (in_ack) check("ack_vld_held", 0, 1);
                in_ack = 0; ack_rdy = 0;
            end
        end
    end

    // Queues the expected APB beat and response, then drives one request
    task automatic xact(input bit wr, input bit rd, input logic [63:0] a, input logic [31:0] d,
                        input int wt, input bit er, input int hd,
                        input bit do_apb, input bit do_ack, input bit lat);
        bit   valid;
        ack_t e;
        int   n;
        valid = wr ^ rd;
        if (valid && do_apb) begin
            apb_q.push_back('{a, wr, d, wt, er});
            apb_exp++;
        end
        if (do_ack) begin
            if (!valid)            e = '{32'h0, 1'b1, hd};
            else if (wt >= c_NEVER) e = '{32'hdead_1eaf, 1'b1, hd};
            else if (wr) begin
                e = '{32'h0, er, hd};
                if (!er) model_mem[a] = d;
            end else               e = '{model_rd(a), er, hd};
            ack_q.push_back(e);
        end
        @(negedge clk);
        req_vld = 1; req_wr_en = wr; req_rd_en = rd; req_addr = a; req_wr_data = d;
        for (n = 0; n < 300 && !req_rdy; n++) @(negedge clk);
        if (!req_rdy) begin
            check("req_rdy_timeout", 0, 1);
            req_vld = 0;
            return;
        end
        @(posedge clk);
        #1 req_vld = 0;
        if (lat) begin
            @(negedge clk);
            check("lat_c1_req_rdy", req_rdy, 0);
            if (valid) begin
                check("lat_c1_PSEL", PSEL, 1);
                check("lat_c1_PENABLE", PENABLE, 0);
                @(negedge clk);
                check("lat_c2_PSEL", PSEL, 1);
                check("lat_c2_PENABLE", PENABLE, 1);
                @(negedge clk);
                check("lat_c3_ack_vld", ack_vld, 1);
                check("lat_c3_PSEL", PSEL, 0);
            end else begin
                check("inv_c1_ack_vld", ack_vld, 1);
                check("inv_c1_PSEL", PSEL, 0);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 500 && (ack_q.size() != 0 || !req_rdy); n++) @(negedge clk);
        check("drain_ack_q", ack_q.size(), 0);
    endtask

    initial begin : driver
        int          k, idx, wt, hd;
        bit          wr, rd, er;
        logic [63:0] a;
        rst = 1; req_vld = 0; req_wr_en = 0; req_rd_en = 0; req_addr = '0;
        req_wr_data = '0; sync_reset = 0;
        repeat (2) @(negedge clk);
        check("rst_PSEL", PSEL, 0);
        check("rst_PENABLE", PENABLE, 0);
        check("rst_ack_vld", ack_vld, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_ack_rd_data", ack_rd_data, 0);
        check("rst_PADDR", PADDR, 0);
        check("rst_PWDATA", PWDATA, 0);
        check("rst_PWRITE", PWRITE, 0);
        rst = 0;
        @(negedge clk);
        check("post_rst_req_rdy", req_rdy, 1);

        xact(1, 0, 64'h10, 32'hA5A5_A5A5, 0, 0, 0, 1, 1, 1);
        xact(1, 0, 64'h20, 32'h1234_5678, 1, 0, 0, 1, 1, 0);
        xact(0, 1, 64'h20, 32'h0, 3, 0, 1, 1, 1, 0);
        xact(0, 1, 64'h30, 32'h0, 1, 1, 4, 1, 1, 0);
        xact(1, 1, 64'h40, 32'hFFFF_0000, 0, 0, 0, 1, 1, 1);
        xact(0, 0, 64'h44, 32'h0, 0, 0, 2, 1, 1, 1);
        wait_drain();

        // sync_reset while the slave is stalling in ACCESS
        xact(0, 1, 64'h50, 32'h0, 20, 0, 0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("abort_in_access", PENABLE, 1);
        sync_reset = 1;
        @(negedge clk);
        sync_reset = 0;
        check("sr_PSEL", PSEL, 0);
        check("sr_PENABLE", PENABLE, 0);
        check("sr_ack_vld", ack_vld, 0);
        check("sr_req_rdy", req_rdy, 1);
        repeat (3) @(negedge clk);

        // asynchronous reset during SETUP
        xact(1, 0, 64'h60, 32'h0BAD_0BAD, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("setup_PSEL", PSEL, 1);
        rst = 1;
        #1;
        check("arst_PSEL", PSEL, 0);
        check("arst_PENABLE", PENABLE, 0);
        @(negedge clk);
        rst = 0;
        check("arst_req_rdy", req_rdy, 1);
        check("arst_ack_vld", ack_vld, 0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            k   = $urandom_range(0, 9);
            wr  = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            rd  = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : !wr;
            idx = $urandom_range(0, 7);
            a   = 64'hA5A5_0000_0000_0000 | 64'(idx * 4);
            wt  = $urandom_range(0, 3);
            er  = ($urandom_range(0, 4) == 0);
            hd  = $urandom_range(0, 2);
            xact(wr, rd, a, $urandom, wt, er, hd, 1, 1, (wt == 0) || (wr == rd));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();

`ifdef REG_APB_MST_TIMEOUT_EN
        xact(0, 1, 64'h70, 32'h0, c_NEVER, 0, 1, 1, 1, 0);
        wait_drain();
        check("timeout_access_cycles", last_pen, c_TIMECNT + 1);
`endif

        repeat (3) @(negedge clk);
        check("apb_q_empty", apb_q.size(), 0);
        check("apb_xfer_count", apb_seen, apb_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, got %0d pending acks, expected 0", ack_q.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
